// File: rtl/lcv_mul32_seq.sv
// ---------------------------------------------------------------------------
// lcv_mul32_seq
//   Sequential 32x32 -> 64-bit multiplier. Operands are split into 16-bit
//   halves and the four 16x16 partial products are accumulated one per cycle,
//   so only a single 16x16 multiplier is needed. One operation in flight.
//
//   Optional feature macro: LCV_MUL32_SEQ_SIGNED_EN
//     defined     : inp_signed honoured (abs-value at accept, FIX negate state)
//     not defined : all operations unsigned, latency always 4 after accept
//
// Handshake: a transfer happens on a rising edge where valid and ready are
//   both 1. inp_ready is high only in IDLE; outp_valid is high only in DONE
//   and outp_prod is held stable until outp_ready is seen.
//
// Ports:
//   clk          in   rising-edge clock
//   rst          in   asynchronous reset, active-low
//   inp_valid    in   operands present
//   inp_ready    out  block can accept (IDLE only)
//   inp_a        in   [31:0] multiplicand
//   inp_b        in   [31:0] multiplier
//   inp_signed   in   1 = two's-complement operands (signed build only)
//   outp_valid   out  product available
//   outp_ready   in   consumer takes product
//   outp_prod    out  [63:0] product (always the accumulator register)
//   dbg_state_o  out  [1:0] current FSM state for debug/checkers
// ---------------------------------------------------------------------------
module lcv_mul32_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        inp_valid,
  output logic        inp_ready,
  input  logic [31:0] inp_a,
  input  logic [31:0] inp_b,
  input  logic        inp_signed,
  output logic        outp_valid,
  input  logic        outp_ready,
  output logic [63:0] outp_prod,
  output logic [1:0]  dbg_state_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  step_q, step_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [63:0] acc_q, acc_d;

  // Operand magnitudes and result sign captured at accept.
  logic [31:0] a_mag, b_mag;
  logic        neg_in;

`ifdef LCV_MUL32_SEQ_SIGNED_EN
  logic neg_q, neg_d;

  // 0 - 0x8000_0000 wraps back to 0x8000_0000, which is the correct
  // magnitude when read as unsigned, so no special case is needed.
  assign a_mag  = (inp_signed && inp_a[31]) ? (32'd0 - inp_a) : inp_a;
  assign b_mag  = (inp_signed && inp_b[31]) ? (32'd0 - inp_b) : inp_b;
  assign neg_in = inp_signed & (inp_a[31] ^ inp_b[31]);
`else
  logic unused_signed;
  assign unused_signed = inp_signed;
  assign a_mag  = inp_a;
  assign b_mag  = inp_b;
  assign neg_in = 1'b0;
`endif

  // Partial product selection: step[1] picks the high half of a, step[0]
  // the high half of b; the shift is 16 per high half used (0/16/16/32).
  logic [15:0] a_half, b_half;
  logic [31:0] pp32;
  logic [5:0]  pp_shamt;
  logic [63:0] pp64;

  assign a_half   = step_q[1] ? a_q[31:16] : a_q[15:0];
  assign b_half   = step_q[0] ? b_q[31:16] : b_q[15:0];
  assign pp32     = a_half * b_half;
  assign pp_shamt = {step_q[1] & step_q[0], step_q[1] ^ step_q[0], 4'b0000};
  assign pp64     = {32'h0, pp32} << pp_shamt;

  always_comb begin
    state_d    = state_q;
    step_d     = step_q;
    a_d        = a_q;
    b_d        = b_q;
    acc_d      = acc_q;
`ifdef LCV_MUL32_SEQ_SIGNED_EN
    neg_d      = neg_q;
`endif
    inp_ready  = 1'b0;
    outp_valid = 1'b0;

    case (state_q)
      S_IDLE: begin
        inp_ready = 1'b1;
        if (inp_valid) begin
          a_d     = a_mag;
          b_d     = b_mag;
`ifdef LCV_MUL32_SEQ_SIGNED_EN
          neg_d   = neg_in;
`endif
          acc_d   = 64'h0;
          step_d  = 2'd0;
          state_d = S_MUL;
        end
      end
      S_MUL: begin
        acc_d  = acc_q + pp64;
        step_d = step_q + 2'd1;
        if (step_q == 2'd3) begin
`ifdef LCV_MUL32_SEQ_SIGNED_EN
          state_d = neg_q ? S_FIX : S_DONE;
`else
          state_d = S_DONE;
`endif
        end
      end
      S_FIX: begin
`ifdef LCV_MUL32_SEQ_SIGNED_EN
        acc_d   = ~acc_q + 64'd1;
        state_d = S_DONE;
`else
        // Unreachable in the unsigned build.
        state_d = S_IDLE;
`endif
      end
      S_DONE: begin
        outp_valid = 1'b1;
        if (outp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      step_q  <= 2'd0;
      a_q     <= 32'h0;
      b_q     <= 32'h0;
      acc_q   <= 64'h0;
`ifdef LCV_MUL32_SEQ_SIGNED_EN
      neg_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
`ifdef LCV_MUL32_SEQ_SIGNED_EN
      neg_q   <= neg_d;
`endif
    end
  end

  assign outp_prod   = acc_q;
  assign dbg_state_o = state_q;

  // neg_in is only consumed by the signed build.
  logic unused_neg;
  assign unused_neg = neg_in;

endmodule
